// File: rtl/serial_adder_n_bits.sv
// serial_adder_n_bits
//   Bit-serial N-bit adder, y = a + b + cin.
//   A single full-adder cell processes one bit per clock, LSB first.
//   Results stay stable until the next accepted operation completes.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted only while ready=1
//   a, b   : N-bit operands, sampled on the accepting edge
//   cin    : carry-in, sampled on the accepting edge
//   ready  : 1 in IDLE
//   busy   : 1 in RUN
//   done   : one-cycle pulse, y/cout/ovf final
//   y      : N-bit sum (modulo 2^N)
//   cout   : carry out of bit N-1
//   ovf    : signed overflow (carry into bit N-1 XOR cout)
module serial_adder_n_bits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  a_sr, b_sr, res_sr;
    logic          carry;
    logic [CW-1:0] cnt;

    // Single full-adder cell on the LSBs of the operand shift registers.
    logic          sum_bit, carry_nxt;
    logic [N-1:0]  res_nxt;

    always_comb begin
        sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        // Sum bits enter at the MSB side, so after N shifts bit 0 lands at LSB.
        res_nxt   = {sum_bit, res_sr[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            y      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // On the MSB step, 'carry' is the carry into bit N-1.
                        y     <= res_nxt;
                        cout  <= carry_nxt;
                        ovf   <= carry ^ carry_nxt;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_adder_n_bits.sv
// Testbench for serial_adder_n_bits: an N=4 and an N=2 instance driven with
// directed and random operations; a scoreboard per instance holds the
// expected result and the edge on which each operation was accepted.
module tb_serial_adder_n_bits;

    typedef struct {
        logic [3:0] y;
        logic       cout;
        logic       ovf;
        int         acc;   // posedge number that accepted the op
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // N=4 instance
    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ready4, busy4, done4, cout4, ovf4;
    logic [3:0] y4;

    serial_adder_n_bits #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .ready(ready4), .busy(busy4), .done(done4), .y(y4), .cout(cout4), .ovf(ovf4)
    );

    // N=2 instance
    logic       start2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       ready2, busy2, done2, cout2, ovf2;
    logic [1:0] y2;

    serial_adder_n_bits #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .ready(ready2), .busy(busy2), .done(done2), .y(y2), .cout(cout2), .ovf(ovf2)
    );

    exp_t q4[$];
    exp_t q2[$];
    logic [3:0] last_y4 = '0;
    logic [3:0] last_y2 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int n, input int a, input int b, input int c, input int acc);
        exp_t e;
        int s, sa, sb, ss, half, full;
        full = 1 << n;
        half = 1 << (n - 1);
        s    = a + b + c;
        sa   = (a >= half) ? a - full : a;
        sb   = (b >= half) ? b - full : b;
        ss   = sa + sb + c;
        e.y    = 4'(s % full);
        e.cout = (s >= full);
        e.ovf  = (ss > half - 1) || (ss < -half);
        e.acc  = acc;
        return e;
    endfunction

    // Monitors: pop and compare whenever an instance raises done.
    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) chk("dut4_spurious_done", 32'(done4), 32'd0);
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_y",       32'(y4),    32'(e.y));
                chk("dut4_cout",    32'(cout4), 32'(e.cout));
                chk("dut4_ovf",     32'(ovf4),  32'(e.ovf));
                chk("dut4_latency", 32'(cyc - e.acc), 32'd4);
            end
        end
        if (rst_n && done2) begin
            if (q2.size() == 0) chk("dut2_spurious_done", 32'(done2), 32'd0);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_y",       32'(y2),    32'(e.y));
                chk("dut2_cout",    32'(cout2), 32'(e.cout));
                chk("dut2_ovf",     32'(ovf2),  32'(e.ovf));
                chk("dut2_latency", 32'(cyc - e.acc), 32'd2);
            end
        end
    end

    // Issue one op on the selected instance (4 or 2); called at a negedge.
    task automatic do_op(input int sel, input int a, input int b, input int c);
        int   to;
        exp_t e;
        to = 0;
        while (((sel == 4) ? !ready4 : !ready2) && to < 20) begin
            @(negedge clk);
            to++;
        end
        if (to >= 20) begin
            chk("ready_timeout", 32'(to), 32'd0);
            return;
        end
        e = model(sel, a, b, c, cyc + 1);
        if (sel == 4) begin
            a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
            q4.push_back(e);
        end else begin
            a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
            q2.push_back(e);
        end
        @(negedge clk);
        // One edge after acceptance: running, previous result still shown.
        if (sel == 4) begin
            start4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            chk("dut4_busy_run", 32'({busy4, ready4}), 32'b10);
            chk("dut4_y_held",   32'(y4), 32'(last_y4));
            last_y4 = e.y;
        end else begin
            start2 = 1'b0;
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
            chk("dut2_busy_run", 32'({busy2, ready2}), 32'b10);
            chk("dut2_y_held",   32'(y2), 32'(last_y2));
            last_y2 = e.y;
        end
    endtask

    initial begin
        // Reset and idle.
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'({ready4, busy4, done4}), 32'b100);
        chk("rst_out",  32'({y4, cout4, ovf4}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", 32'({ready4, busy4, done4, y4, cout4, ovf4}), 32'b100_0000_00);
        chk("idle_hold2", 32'({ready2, busy2, done2, y2, cout2, ovf2}), 32'b100_00_00);

        // Directed vectors.
        do_op(4, 4'b0011, 4'b0101, 0);
        do_op(4, 4'b1111, 4'b0001, 0);
        do_op(4, 4'b0111, 4'b1000, 1);

        // Start while busy is ignored; a changes after acceptance have no effect.
        do_op(4, 4'b0011, 4'b0101, 0);
        a4 = 4'b1111; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-operation: discarded, outputs cleared at once.
        a4 = 4'b1010; b4 = 4'b0110; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 32'({ready4, busy4, done4}), 32'b100);
        chk("midrst_out",  32'({y4, cout4, ovf4}), 32'd0);
        last_y4 = '0;
        last_y2 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", 32'(q4.size()), 32'd0);
        do_op(4, 4'b0100, 4'b0100, 0);

        // N=2 directed, then start held high back-to-back (period N+2 = 4).
        do_op(2, 2'b11, 2'b11, 0);
        repeat (4) @(negedge clk);
        a2 = 2'b11; b2 = 2'b11; cin2 = 1'b0; start2 = 1'b1;
        for (int k = 0; k < 3; k++) q2.push_back(model(2, 3, 3, 0, cyc + 1 + 4 * k));
        repeat (9) @(negedge clk);
        start2 = 1'b0;
        last_y2 = 4'b0010;
        repeat (6) @(negedge clk);

        // Random operations on both widths.
        for (int i = 0; i < 30; i++) do_op(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        for (int i = 0; i < 12; i++) do_op(2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));

        // Drain, bounded.
        for (int i = 0; i < 50 && (q4.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
